bdcpu_core_p: RTL and testbench

Parametrised, bus-less successor of the 8-bit accumulator CPU: same accumulator ISA, with generic data and address widths, a ready-based memory handshake that tolerates wait states, and an optional subroutine call. It connects directly to a synchronous memory or memory controller through a single shared read/write port. It also drives a registered output port. The internal tri-state bus is replaced by muxes.

---
 rtl/bdcpu_core_p_if.sv | 31 +++
 rtl/bdcpu_core_p.sv | 148 ++++++++++++++
 tb/tb_bdcpu_core_p.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bdcpu_core_p_if.sv
// Memory port of bdcpu_core_p: one shared read/write port with a ready handshake.
// The core drives the request side; memory or a controller answers with rdata/ready.
interface bdcpu_core_p_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_address,
    output mem_read,
    output mem_write,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    input  mem_write,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/bdcpu_core_p.sv
// Parametrised accumulator CPU with a ready-based memory port.
// Define BDCPU_CALL_EN to add CALL/RET through a single link register.
module bdcpu_core_p #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  bdcpu_core_p_if.master        mem,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  halted
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_STA  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JC   = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_CALL = 4'h9;
  localparam logic [3:0] OP_RET  = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] a_q;
  logic          c_q;
  logic          z_q;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q;
  logic          halted_q;
`ifdef BDCPU_CALL_EN
  logic [AW-1:0] lr_q;
`endif

  logic [3:0]    op;
  logic [DW-5:0] opnd;
  logic [AW-1:0] ir_addr;
  logic [DW:0]   sum;
  logic [DW:0]   dif;

  assign op      = ir_q[DW-1 -: 4];
  assign opnd    = ir_q[DW-5:0];
  assign ir_addr = opnd[AW-1:0];
  assign sum     = {1'b0, a_q} + {1'b0, mem.mem_rdata};
  assign dif     = {1'b0, a_q} - {1'b0, mem.mem_rdata};

  // Requests come straight off the state register, gated so reset kills them at once.
  assign mem.mem_read  = !reset &&
                         ((state_q == S_FETCH) ||
                          (state_q == S_MEM && op != OP_STA));
  assign mem.mem_write = !reset && (state_q == S_MEM) && (op == OP_STA);
  assign mem.mem_address = (state_q == S_FETCH) ? pc_q : ir_addr;
  assign mem.mem_wdata   = a_q;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      a_q         <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      ir_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
`ifdef BDCPU_CALL_EN
      lr_q        <= '0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (mem.mem_ready) begin
            ir_q    <= mem.mem_rdata;
            pc_q    <= pc_q + 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: state_q <= S_MEM;
            OP_LDI: a_q <= {4'b0000, opnd};
            OP_JMP: pc_q <= ir_addr;
            OP_JC:  if (c_q) pc_q <= ir_addr;
            OP_JZ:  if (z_q) pc_q <= ir_addr;
`ifdef BDCPU_CALL_EN
            OP_CALL: begin
              lr_q <= pc_q;
              pc_q <= ir_addr;
            end
            OP_RET: pc_q <= lr_q;
`endif
            OP_OUT: begin
              out_data_q  <= a_q;
              out_valid_q <= 1'b1;
            end
            OP_HLT: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (mem.mem_ready) begin
            state_q <= S_FETCH;
            case (op)
              OP_LDA: a_q <= mem.mem_rdata;
              OP_ADD: begin
                {c_q, a_q} <= sum;
                z_q        <= (sum[DW-1:0] == '0);
              end
              OP_SUB: begin
                {c_q, a_q} <= dif;
                z_q        <= (dif[DW-1:0] == '0);
              end
              default: ;
            endcase
          end
        end
        S_HALT: ;
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_bdcpu_core_p.sv
// Scoreboard bench for bdcpu_core_p: directed programs, expected bus
// transactions and OUT values are queued and checked by a monitor.
module tb_bdcpu_core_p;
  localparam int DW = 8;
  localparam int AW = 4;

  typedef struct {
    bit             wr;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } txn_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bdcpu_core_p_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          halted;

  bdcpu_core_p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .mem      (bus),
    .out_data (out_data),
    .out_valid(out_valid),
    .halted   (halted)
  );

  logic [DW-1:0] prog [16];
  logic [DW-1:0] mem  [16];
  logic ready = 1'b1;
  logic stall = 1'b0;
  int   write_waits = 0;
  int   wcnt = 0;
  int   nwrites = 0;

  int errors = 0;
  int checks = 0;

  txn_t          mem_q [$];
  logic [DW-1:0] out_q [$];

  assign bus.mem_rdata = mem[bus.mem_address];
  assign bus.mem_ready = ready && !stall;

  // memory model: program image copied in while reset is held
  always @(posedge clock) begin
    if (reset) begin
      mem <= prog;
    end else if (bus.mem_write && bus.mem_ready) begin
      mem[bus.mem_address] <= bus.mem_wdata;
      nwrites <= nwrites + 1;
    end
  end

  // wait-state generator for writes
  always @(posedge clock) begin
    #1;
    if (bus.mem_write && wcnt < write_waits) begin
      ready = 1'b0;
      wcnt++;
    end else begin
      ready = 1'b1;
    end
    if (!bus.mem_write) wcnt = 0;
  end

  // monitor: pops an expectation on every completed transaction and OUT pulse
  always @(negedge clock) begin
    if (!reset) begin
      if ((bus.mem_read || bus.mem_write) && bus.mem_ready) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL txn_unexpected: got wr=%0b addr=%h, required none",
                   bus.mem_write, bus.mem_address);
        end else begin
          txn_t e;
          e = mem_q.pop_front();
          if ((bus.mem_read && bus.mem_write) || e.wr != bus.mem_write ||
              e.addr != bus.mem_address ||
              (e.wr && e.data != bus.mem_wdata)) begin
            errors++;
            $display("FAIL txn: got rd=%0b wr=%0b addr=%h wdata=%h, required wr=%0b addr=%h wdata=%h",
                     bus.mem_read, bus.mem_write, bus.mem_address,
                     bus.mem_wdata, e.wr, e.addr, e.data);
          end
        end
      end
      if (out_valid) begin
        checks++;
        if (out_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got %h, required none", out_data);
        end else begin
          logic [DW-1:0] d;
          d = out_q.pop_front();
          if (out_data != d) begin
            errors++;
            $display("FAIL out: got %h, required %h", out_data, d);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic exp_rd(input logic [AW-1:0] a);
    txn_t t;
    t.wr = 1'b0; t.addr = a; t.data = '0;
    mem_q.push_back(t);
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.wr = 1'b1; t.addr = a; t.data = d;
    mem_q.push_back(t);
  endtask

  task automatic exp_rds(input int n, input logic [AW-1:0] seq [16]);
    for (int i = 0; i < n; i++) exp_rd(seq[i]);
  endtask

  task automatic clr_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'hF0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    mem_q.delete();
    out_q.delete();
    chk("reset_state",
        {bus.mem_read, bus.mem_write, out_valid, halted, out_data,
         bus.mem_address}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && (mem_q.size() != 0 || out_q.size() != 0); i++)
      begin
        @(negedge clock);
        #1;
      end
    chk(name, mem_q.size() + out_q.size(), 0);
  endtask

  logic [AW-1:0] seq [16];

  initial begin
    int reqs, wcyc, unstable, w0;

    // LDI 1; OUT; HLT
    clr_prog();
    prog[0] = 8'h51; prog[1] = 8'hE0; prog[2] = 8'hF0;
    do_reset();
    exp_rd(0); exp_rd(1); exp_rd(2);
    out_q.push_back(8'h01);
    repeat (5) @(posedge clock);
    #1 chk("halt_c5", halted, 0);
    @(posedge clock);
    #1 chk("halt_c6", halted, 1);
    reqs = 0;
    repeat (5) begin
      @(negedge clock);
      reqs += int'(bus.mem_read | bus.mem_write);
    end
    chk("halt_idle", reqs, 0);
    drain("drain_t1");

    // ADD without carry: JC and JZ not taken
    clr_prog();
    prog[0] = 8'h5F; prog[1] = 8'h2C; prog[2] = 8'h76; prog[3] = 8'h86;
    prog[4] = 8'hE0; prog[6] = 8'hE0; prog[12] = 8'h01;
    do_reset();
    seq = '{0, 1, 12, 2, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_rds(7, seq);
    out_q.push_back(8'h10);
    drain("drain_add_nc");

    // ADD with carry out to zero: JC taken
    prog[12] = 8'hF1;
    do_reset();
    seq = '{0, 1, 12, 2, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_rds(6, seq);
    out_q.push_back(8'h00);
    drain("drain_add_c");

    // SUB borrow, then SUB to zero
    clr_prog();
    prog[0] = 8'h53; prog[1] = 8'h3C; prog[2] = 8'h76; prog[6] = 8'hE0;
    prog[7] = 8'h55; prog[8] = 8'h3C; prog[9] = 8'h7B; prog[10] = 8'h8D;
    prog[12] = 8'h05; prog[13] = 8'hE0;
    do_reset();
    seq = '{0, 1, 12, 2, 6, 7, 8, 12, 9, 10, 13, 14, 0, 0, 0, 0};
    exp_rds(12, seq);
    out_q.push_back(8'hFE);
    out_q.push_back(8'h00);
    drain("drain_sub");

    // STA with three wait states
    clr_prog();
    prog[0] = 8'h57; prog[1] = 8'h4A; prog[2] = 8'hF0;
    write_waits = 3;
    do_reset();
    w0 = nwrites;
    exp_rd(0); exp_rd(1); exp_wr(4'hA, 8'h07); exp_rd(2);
    wcyc = 0;
    unstable = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clock);
      #1;
      if (bus.mem_write) begin
        wcyc++;
        if (bus.mem_address != 4'hA || bus.mem_wdata != 8'h07 ||
            bus.mem_read) unstable++;
      end
      if (cyc == 9)  chk("sta_halt_c9", halted, 0);
      if (cyc == 10) chk("sta_halt_c10", halted, 1);
    end
    chk("sta_write_cycles", wcyc, 4);
    chk("sta_stable", unstable, 0);
    chk("sta_write_once", nwrites - w0, 1);
    chk("sta_mem", mem[10], 8'h07);
    drain("drain_sta");
    write_waits = 0;

    // PC wrap from 0xF to 0x0, Z set by ADD of zero
    clr_prog();
    prog[0] = 8'h8E; prog[1] = 8'h2D; prog[2] = 8'h6F;
    prog[13] = 8'h00; prog[15] = 8'h00;
    do_reset();
    seq = '{0, 1, 13, 2, 15, 0, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_rds(7, seq);
    drain("drain_wrap");

    // Reset asserted while a fetch is waiting
    clr_prog();
    prog[0] = 8'h5C; prog[1] = 8'h6A;
    stall = 1'b1;
    do_reset();
    repeat (3) @(negedge clock);
    #1 chk("stall_req", {bus.mem_read, bus.mem_write, bus.mem_address},
           {1'b1, 1'b0, 4'h0});
    prog[0] = 8'hE0; prog[1] = 8'hF0;
    reset = 1'b1;
    #1 chk("reset_drop", {bus.mem_read, bus.mem_write}, 2'b00);
    stall = 1'b0;
    do_reset();
    exp_rd(0); exp_rd(1);
    out_q.push_back(8'h00);
    drain("drain_rst");

    // CALL 8 at address 2, RET at 8
    clr_prog();
    prog[0] = 8'h00; prog[1] = 8'h00; prog[2] = 8'h98; prog[8] = 8'hA0;
    do_reset();
`ifdef BDCPU_CALL_EN
    seq = '{0, 1, 2, 8, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_rds(5, seq);
`else
    seq = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_rds(4, seq);
`endif
    drain("drain_call");
    repeat (4) @(negedge clock);
    chk("call_halted", halted, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
